instr_sequencer: RTL

Instruction issuer for the 16x8 register/memory executor. It buffers a program of 16-bit instructions, `{opcode[15:12], src1[11:8], src2[7:4], dst[3:0]}`, loaded over a valid/ready port. On `start` it drives them onto the executor's `instruction` input, one per clock, with a qualifying `instr_valid` strobe. It sits between the testbench or host loader and the executor, replacing direct testbench driving of `instruction`.

---
 rtl/instr_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Program buffer and issuer: loads 16-bit words over valid/ready, then streams them one per clock.
// Build option SEQ_LOOP_EN: replay the program endlessly until stop instead of completing through DONE.
module instr_sequencer #(
   parameter int              DEPTH    = 16,
   parameter int              AW       = 4,
   parameter logic [15:0]     NOP_WORD = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [15:0]       load_data,
   input  logic              clear,
   input  logic              start,
   input  logic              stop,
   output logic [AW:0]       prog_len,
   output logic [AW-1:0]     pc,
   output logic              busy,
   output logic              done,
   output logic [15:0]       instruction,
   output logic              instr_valid
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PC_ONE   = AW'(1);

   state_t        state;
   logic [AW:0]   count;
   logic [15:0]   mem [DEPTH];
   logic          load_fire;

   function automatic logic is_last(input logic [AW-1:0] p, input logic [AW:0] c);
      return ({1'b0, p} == (c - CNT_ONE));
   endfunction

   assign load_ready = (state == IDLE) && (count < CNT_FULL);
   assign load_fire  = load_valid && load_ready && !clear;
   assign prog_len   = count;
   assign busy       = (state == RUN);

   // Program storage is deliberately not reset; count defines what is valid.
   always_ff @(posedge clk) begin
      if (load_fire)
         mem[count[AW-1:0]] <= load_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         pc          <= '0;
         instruction <= NOP_WORD;
         instr_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               instr_valid <= 1'b0;
               instruction <= NOP_WORD;
               if (clear) begin
                  count <= '0;
               end else begin
                  if (load_fire)
                     count <= count + CNT_ONE;
                  // Acceptance looks at the pre-edge count, so a same-cycle load cannot rescue an empty start.
                  if (start && (count != '0)) begin
                     state <= RUN;
                     pc    <= '0;
                  end
               end
            end
            RUN: begin
               if (stop) begin
                  instr_valid <= 1'b0;
                  instruction <= NOP_WORD;
                  state       <= IDLE;
               end else begin
                  instruction <= mem[pc];
                  instr_valid <= 1'b1;
`ifdef SEQ_LOOP_EN
                  if (is_last(pc, count))
                     pc <= '0;
                  else
                     pc <= pc + PC_ONE;
`else
                  pc <= pc + PC_ONE;
                  if (is_last(pc, count))
                     state <= DONE;
`endif
               end
            end
            DONE: begin
               instr_valid <= 1'b0;
               instruction <= NOP_WORD;
               done        <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               instr_valid <= 1'b0;
               instruction <= NOP_WORD;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
